// File: rtl/rc4_phase_sequencer.sv
// RC4 top-level sequencer: runs LOAD, INIT, SHUFFLE, DECRYPT in order, supervises
// each phase with a timeout, and grants the single-port S-box RAM to the active phase.
module rc4_phase_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  output logic [3:0]                       phase_start,
  input  logic [3:0]                       phase_finished,
  input  logic [2:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [2:0][DATA_WIDTH-1:0]       req_data,
  input  logic [2:0]                       req_wren,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data,
  output logic                             mem_wren,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       err_phase,
  output logic [2:0]                       state_tap,
  output logic [1:0]                       phase_tap
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int                 TIMER_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT   = '1;
  localparam logic [1:0]         LAST_PHASE  = 2'd3;

  state_t             state;
  logic [1:0]         phase;
  logic [TIMER_W-1:0] timer;
  logic               start_q;
  logic [3:0]         finished_q;
  logic               start_rise;
  logic [3:0]         fin_rise;

  // Only fresh 0->1 transitions count; a level left high by an earlier run is ignored.
  assign start_rise = start & ~start_q;
  assign fin_rise   = phase_finished & ~finished_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      timer      <= '0;
      err_phase  <= '0;
      start_q    <= 1'b0;
      finished_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so the edge detectors and the FSM see a consistent snapshot.
      start_q    <= start;
      finished_q <= phase_finished;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        phase <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_rise) begin
              state     <= ST_LAUNCH;
              phase     <= '0;
              err_phase <= '0;
            end
          end
          ST_LAUNCH: begin
            timer <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (timer != TIMER_SAT) timer <= timer + TIMER_W'(1);
            // A finish arriving on the timeout cycle still counts as success.
            if (fin_rise[phase]) begin
              if (phase == LAST_PHASE) begin
                state <= ST_DONE;
              end else begin
                phase <= phase + 2'd1;
                state <= ST_LAUNCH;
              end
            end else if (timer == TIMER_LIMIT) begin
              state     <= ST_ERROR;
              err_phase <= phase;
            end
          end
          default: begin
            state <= ST_IDLE;
            phase <= '0;
          end
        endcase
      end
    end
  end

  assign phase_start = (state == ST_LAUNCH) ? (4'b0001 << phase) : 4'b0000;
  assign busy        = (state == ST_LAUNCH) || (state == ST_WAIT);
  assign done        = (state == ST_DONE);
  assign error       = (state == ST_ERROR);
  assign state_tap   = state;
  assign phase_tap   = phase;

  // LOAD (phase 0) has no RAM requester, so it never owns the port.
  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (busy) begin
      case (phase)
        2'd1: begin
          mem_addr = req_addr[0];
          mem_data = req_data[0];
          mem_wren = req_wren[0];
        end
        2'd2: begin
          mem_addr = req_addr[1];
          mem_data = req_data[1];
          mem_wren = req_wren[1];
        end
        2'd3: begin
          mem_addr = req_addr[2];
          mem_data = req_data[2];
          mem_wren = req_wren[2];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: instance a has a long timeout for
// nominal runs, instance b a 16-cycle timeout for the error path.
module tb_rc4_phase_sequencer;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [3:0]       phase_finished;
  logic [2:0][7:0]  req_addr;
  logic [2:0][7:0]  req_data;
  logic [2:0]       req_wren;

  logic [3:0] phase_start_a, phase_start_b;
  logic [7:0] mem_addr_a, mem_addr_b, mem_data_a, mem_data_b;
  logic       mem_wren_a, mem_wren_b, busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [1:0] err_phase_a, err_phase_b, phase_tap_a, phase_tap_b;
  logic [2:0] state_tap_a, state_tap_b;

  int checks   = 0;
  int failures = 0;
  logic [3:0] pulse_log [$];

  rc4_phase_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(1024)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .phase_start(phase_start_a), .phase_finished(phase_finished),
    .req_addr(req_addr), .req_data(req_data), .req_wren(req_wren),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .mem_wren(mem_wren_a),
    .busy(busy_a), .done(done_a), .error(error_a), .err_phase(err_phase_a),
    .state_tap(state_tap_a), .phase_tap(phase_tap_a)
  );

  rc4_phase_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .phase_start(phase_start_b), .phase_finished(phase_finished),
    .req_addr(req_addr), .req_data(req_data), .req_wren(req_wren),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b),
    .busy(busy_b), .done(done_b), .error(error_b), .err_phase(err_phase_b),
    .state_tap(state_tap_b), .phase_tap(phase_tap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (phase_start_a != 4'b0000) pulse_log.push_back(phase_start_a);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch();
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
  endtask

  task automatic fin_pulse(input int k);
    phase_finished[k] = 1'b1;
    step(1);
    phase_finished[k] = 1'b0;
  endtask

  task automatic idle_all();
    abort = 1'b1;
    step(1);
    abort          = 1'b0;
    req_wren       = 3'b000;
    phase_finished = 4'b0000;
    step(1);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (state_tap_a !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state_tap_a); end
    checks++; if ({phase_start_a, busy_a, done_a, error_a, err_phase_a, phase_tap_a} !== 11'd0) begin
      failures++; $display("FAIL reset_outputs got=%b want=0", {phase_start_a, busy_a, done_a, error_a, err_phase_a, phase_tap_a}); end
    checks++; if ({mem_addr_a, mem_data_a, mem_wren_a} !== 17'd0) begin
      failures++; $display("FAIL reset_mem got=%h want=0", {mem_addr_a, mem_data_a, mem_wren_a}); end
    #9;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_nominal();
    int dur [4] = '{40, 256, 768, 96};
    logic [3:0] exp_ps;
    idle_all();
    pulse_log.delete();
    launch();
    checks++; if (phase_start_a !== 4'b0001) begin failures++; $display("FAIL nom_first_pulse got=%b want=0001", phase_start_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL nom_busy got=%b want=1", busy_a); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      step(dur[k] - 1);
      checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== k[1:0]) begin
        failures++; $display("FAIL nom_wait%0d got=%0d/%0d want=2/%0d", k, state_tap_a, phase_tap_a, k); end
      if (k == 3) begin
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL nom_done_early got=%b want=0", done_a); end
      end
      fin_pulse(k);
      if (k < 3) begin
        exp_ps = 4'b0001 << (k + 1);
        checks++; if (phase_start_a !== exp_ps) begin failures++; $display("FAIL nom_pulse%0d got=%b want=%b", k + 1, phase_start_a, exp_ps); end
      end else begin
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL nom_done got=%b/%b want=1/0", done_a, busy_a); end
      end
    end
    step(2);
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL nom_done_level got=%b want=1", done_a); end
    checks++; if (pulse_log.size() !== 4) begin failures++; $display("FAIL nom_pulse_count got=%0d want=4", pulse_log.size()); end
    for (int i = 0; i < 4 && i < pulse_log.size(); i++) begin
      exp_ps = 4'b0001 << i;
      checks++; if (pulse_log[i] !== exp_ps) begin failures++; $display("FAIL nom_order%0d got=%b want=%b", i, pulse_log[i], exp_ps); end
    end
    start = 1'b0;
  endtask

  task automatic test_mux();
    idle_all();
    req_addr = {8'h33, 8'h5A, 8'h11};
    req_data = {8'h77, 8'h3C, 8'h22};
    req_wren = 3'b111;
    launch();
    checks++; if (mem_wren_a !== 1'b0 || mem_addr_a !== 8'h00) begin failures++; $display("FAIL mux_load_launch got=%b/%h want=0/00", mem_wren_a, mem_addr_a); end
    step(1);
    checks++; if (mem_wren_a !== 1'b0 || mem_data_a !== 8'h00) begin failures++; $display("FAIL mux_load_wait got=%b/%h want=0/00", mem_wren_a, mem_data_a); end
    req_wren = 3'b001;
    fin_pulse(0);
    checks++; if ({mem_addr_a, mem_data_a, mem_wren_a} !== {8'h11, 8'h22, 1'b1}) begin
      failures++; $display("FAIL mux_init got=%h/%h/%b want=11/22/1", mem_addr_a, mem_data_a, mem_wren_a); end
    step(1);
    req_wren = 3'b010;
    fin_pulse(1);
    checks++; if ({mem_addr_a, mem_data_a, mem_wren_a} !== {8'h5A, 8'h3C, 1'b1}) begin
      failures++; $display("FAIL mux_shuffle_launch got=%h/%h/%b want=5a/3c/1", mem_addr_a, mem_data_a, mem_wren_a); end
    step(1);
    checks++; if ({mem_addr_a, mem_data_a, mem_wren_a} !== {8'h5A, 8'h3C, 1'b1}) begin
      failures++; $display("FAIL mux_shuffle_wait got=%h/%h/%b want=5a/3c/1", mem_addr_a, mem_data_a, mem_wren_a); end
    req_wren = 3'b101;
    #1;
    checks++; if (mem_wren_a !== 1'b0) begin failures++; $display("FAIL mux_shuffle_nowr got=%b want=0", mem_wren_a); end
    req_wren = 3'b100;
    fin_pulse(2);
    checks++; if ({mem_addr_a, mem_data_a, mem_wren_a} !== {8'h33, 8'h77, 1'b1}) begin
      failures++; $display("FAIL mux_decrypt got=%h/%h/%b want=33/77/1", mem_addr_a, mem_data_a, mem_wren_a); end
    step(1);
    req_wren = 3'b111;
    fin_pulse(3);
    checks++; if (done_a !== 1'b1 || mem_wren_a !== 1'b0 || mem_addr_a !== 8'h00) begin
      failures++; $display("FAIL mux_done got=%b/%b/%h want=1/0/00", done_a, mem_wren_a, mem_addr_a); end
    start = 1'b0;
  endtask

  task automatic test_stale();
    idle_all();
    phase_finished = 4'b1111;
    step(2);
    launch();
    step(11);
    checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== 2'd0) begin failures++; $display("FAIL stale_hold0 got=%0d/%0d want=2/0", state_tap_a, phase_tap_a); end
    phase_finished[0] = 1'b0;
    step(1);
    checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== 2'd0) begin failures++; $display("FAIL stale_fall0 got=%0d/%0d want=2/0", state_tap_a, phase_tap_a); end
    phase_finished[0] = 1'b1;
    step(1);
    checks++; if (phase_start_a !== 4'b0010 || phase_tap_a !== 2'd1) begin failures++; $display("FAIL stale_advance got=%b/%0d want=0010/1", phase_start_a, phase_tap_a); end
    step(6);
    checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== 2'd1) begin failures++; $display("FAIL stale_hold1 got=%0d/%0d want=2/1", state_tap_a, phase_tap_a); end
    phase_finished[1] = 1'b0;
    phase_finished[2] = 1'b0;
    step(1);
    phase_finished[1] = 1'b1;
    step(1);
    checks++; if (state_tap_a !== 3'd1 || phase_tap_a !== 2'd2) begin failures++; $display("FAIL stale_launch2 got=%0d/%0d want=1/2", state_tap_a, phase_tap_a); end
    phase_finished[2] = 1'b1;
    step(4);
    checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== 2'd2) begin failures++; $display("FAIL launch_rise_consumed got=%0d/%0d want=2/2", state_tap_a, phase_tap_a); end
    phase_finished[3] = 1'b0;
    step(1);
    phase_finished[3] = 1'b1;
    step(2);
    checks++; if (state_tap_a !== 3'd2 || phase_tap_a !== 2'd2) begin failures++; $display("FAIL other_bit_ignored got=%0d/%0d want=2/2", state_tap_a, phase_tap_a); end
  endtask

  task automatic test_abort();
    idle_all();
    launch();
    step(1);
    fin_pulse(0);
    step(1);
    fin_pulse(1);
    step(3);
    req_wren = 3'b010;
    #1;
    checks++; if (mem_wren_a !== 1'b1 || phase_tap_a !== 2'd2) begin failures++; $display("FAIL abort_pre got=%b/%0d want=1/2", mem_wren_a, phase_tap_a); end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++; if (state_tap_a !== 3'd0 || mem_wren_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=%0d/%b/%b want=0/0/0", state_tap_a, mem_wren_a, busy_a); end
    step(3);
    checks++; if (state_tap_a !== 3'd0) begin failures++; $display("FAIL abort_stays_idle got=%0d want=0", state_tap_a); end
    launch();
    checks++; if (phase_start_a !== 4'b0001) begin failures++; $display("FAIL abort_relaunch got=%b want=0001", phase_start_a); end
  endtask

  task automatic test_timeout();
    start = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    idle_all();
    launch();
    step(1);
    fin_pulse(0);
    checks++; if (state_tap_b !== 3'd1 || phase_tap_b !== 2'd1) begin failures++; $display("FAIL to_launch1 got=%0d/%0d want=1/1", state_tap_b, phase_tap_b); end
    req_wren = 3'b111;
    step(16);
    checks++; if (state_tap_b !== 3'd2 || error_b !== 1'b0) begin failures++; $display("FAIL to_wait16 got=%0d/%b want=2/0", state_tap_b, error_b); end
    step(1);
    checks++; if (error_b !== 1'b1 || err_phase_b !== 2'd1 || state_tap_b !== 3'd4) begin
      failures++; $display("FAIL to_error got=%b/%0d/%0d want=1/1/4", error_b, err_phase_b, state_tap_b); end
    step(3);
    checks++; if (mem_wren_b !== 1'b0 || busy_b !== 1'b0 || err_phase_b !== 2'd1) begin
      failures++; $display("FAIL to_hold got=%b/%b/%0d want=0/0/1", mem_wren_b, busy_b, err_phase_b); end
    launch();
    checks++; if (error_b !== 1'b0 || err_phase_b !== 2'd0 || phase_start_b !== 4'b0001) begin
      failures++; $display("FAIL to_relaunch got=%b/%0d/%b want=0/0/0001", error_b, err_phase_b, phase_start_b); end
  endtask

  task automatic test_timeout_tie();
    idle_all();
    launch();
    step(1);
    fin_pulse(0);
    step(16);
    phase_finished[1] = 1'b1;
    step(1);
    phase_finished[1] = 1'b0;
    checks++; if (state_tap_b !== 3'd1 || phase_tap_b !== 2'd2 || error_b !== 1'b0) begin
      failures++; $display("FAIL tie_fin_wins got=%0d/%0d/%b want=1/2/0", state_tap_b, phase_tap_b, error_b); end
  endtask

  task automatic test_async_reset();
    idle_all();
    launch();
    step(1);
    fin_pulse(0);
    step(1);
    fin_pulse(1);
    step(1);
    fin_pulse(2);
    step(2);
    req_wren = 3'b100;
    #1;
    checks++; if (mem_wren_a !== 1'b1 || phase_tap_a !== 2'd3) begin failures++; $display("FAIL ar_pre got=%b/%0d want=1/3", mem_wren_a, phase_tap_a); end
    reset = 1'b1;
    #1;
    checks++; if ({state_tap_a, phase_tap_a, phase_start_a, busy_a, mem_wren_a, mem_addr_a} !== 19'd0) begin
      failures++; $display("FAIL ar_immediate got=%h want=0", {state_tap_a, phase_tap_a, phase_start_a, busy_a, mem_wren_a, mem_addr_a}); end
    checks++; if ({error_b, err_phase_b, done_a} !== 4'd0) begin failures++; $display("FAIL ar_flags got=%b want=0", {error_b, err_phase_b, done_a}); end
    start = 1'b0;
    #3;
    reset = 1'b0;
    step(4);
    checks++; if (state_tap_a !== 3'd0 || busy_a !== 1'b0 || phase_start_a !== 4'b0000) begin
      failures++; $display("FAIL ar_idle got=%0d/%b/%b want=0/0/0000", state_tap_a, busy_a, phase_start_a); end
    start = 1'b1;
    step(1);
    checks++; if (phase_start_a !== 4'b0001) begin failures++; $display("FAIL ar_restart got=%b want=0001", phase_start_a); end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    phase_finished = 4'b0000;
    req_addr       = '0;
    req_data       = '0;
    req_wren       = 3'b000;
    test_reset();
    test_nominal();
    test_mux();
    test_stale();
    test_abort();
    test_timeout();
    test_timeout_tie();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_phase_sequencer.md
Name: rc4_phase_sequencer

Overview:
Top-level controller for the RC4 decryption datapath. It runs four phases in a fixed order: LOAD (key ROM loader), INIT (S[i]=i fill), SHUFFLE (key schedule) and DECRYPT (keystream/XOR). Each phase gets a one-cycle start pulse, and the sequencer waits for that phase's finished rising edge. It also owns the mux on the single-port S-box RAM and grants it to whichever phase is active.

Parameters:
ADDR_WIDTH, 8, S-RAM address width
DATA_WIDTH, 8, S-RAM data width
TIMEOUT_CYCLES, 4096, max cycles any phase may take before error; must be >= 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; a rising edge launches a full run
abort  in  1  synchronous; returns the sequencer to IDLE
phase_start  out  4  one-hot one-cycle start pulse; bit0=LOAD, bit1=INIT, bit2=SHUFFLE, bit3=DECRYPT
phase_finished  in  4  level finished flag from each phase block
req_addr  in  3x ADDR_WIDTH  S-RAM address from INIT/SHUFFLE/DECRYPT (index 0..2)
req_data  in  3x DATA_WIDTH  S-RAM write data, same indexing
req_wren  in  3  S-RAM write enable, same indexing
mem_addr  out  ADDR_WIDTH  to S-RAM
mem_data  out  DATA_WIDTH  to S-RAM
mem_wren  out  1  to S-RAM
busy  out  1  high in LAUNCH or WAIT
done  out  1  high in DONE
error  out  1  high in ERROR
err_phase  out  2  phase index that timed out; held until next launch
state_tap  out  3  current state encoding
phase_tap  out  2  current phase index

Behaviour:
- Reset (async, active-high):
  - state=IDLE, phase=0, timer=0, err_phase=0, start_q=0, finished_q=0.
  - All outputs are 0.
- Edge detection:
  - start_q and finished_q are registered copies updated every cycle.
  - start_rise = start & ~start_q.
  - fin_rise[k] = phase_finished[k] & ~finished_q[k].
- State encodings: IDLE=0, LAUNCH=1, WAIT=2, DONE=3, ERROR=4.
- IDLE: on start_rise, go to LAUNCH with phase=0.
- LAUNCH (exactly 1 cycle):
  - phase_start[phase]=1; all other bits are 0.
  - timer cleared; go to WAIT.
  - phase_start is decoded from registered state, so it is high in the cycle after the edge at which start_rise was sampled.
- WAIT:
  - timer increments each cycle.
  - If fin_rise[phase]: when phase==3, go to DONE; otherwise phase+1 and go to LAUNCH.
  - Else if timer==TIMEOUT_CYCLES-1: go to ERROR and capture err_phase=phase.
  - If fin_rise and the timeout limit occur in the same cycle, fin_rise wins.
  - fin_rise on a non-current phase bit is ignored.
  - A stale finished level that stays high from a previous run never counts; only a fresh 0->1 seen in WAIT counts. A rise that happens during LAUNCH is consumed and not counted.
- Inter-phase gap: 1 cycle (the LAUNCH cycle after the finishing WAIT cycle).
- DONE: done=1 (level). On start_rise, go to LAUNCH with phase=0; done drops.
- ERROR: error=1 (level). On start_rise, go to LAUNCH with phase=0; error drops. err_phase holds until that relaunch, then clears to 0.
- abort:
  - Highest priority in every state except IDLE; next state is IDLE with phase=0.
  - Phase blocks are not reset; on relaunch they see a fresh start pulse.
- start_rise while busy: ignored.
- S-RAM mux (combinational, from registered state/phase):
  - In LAUNCH or WAIT with phase in 1..3, mem_* = req_*[phase-1].
  - In all other cases (including phase 0) mem_addr=0, mem_data=0, mem_wren=0.
  - mem_wren must never be 1 in IDLE, DONE or ERROR, nor on the cycle after abort.
- Timer width: $clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.

Test Plan:
- Nominal run: reset, then start 0->1. Expect phase_start=0001 for 1 cycle. Pulse phase_finished[0] 0->1 after 40 cycles → 0010. Repeat for phases 1–3 (finish after 256, 768, 96 cycles). Required: done=1 exactly 1 cycle after the DECRYPT finish edge; busy=0; phase_start seen exactly 4 times, one-hot, in order.
- Stale finished: hold phase_finished=1111 from before start. Required: the sequencer stays in WAIT on phase 0 until phase_finished[0] goes 0 then 1; no premature advance.
- Timeout: TIMEOUT_CYCLES=16; phase 1 (INIT) never finishes. Required: error=1 and err_phase=1 at the 16th WAIT cycle; mem_wren=0 afterwards; a new start edge relaunches at phase 0 with error=0 and err_phase=0.
- Mux ownership: during SHUFFLE, req_addr[1]=0x5A, req_data[1]=0x3C, req_wren=010. Required: mem_addr=0x5A, mem_data=0x3C, mem_wren=1. Driving req_wren=111 during LOAD gives mem_wren=0.
- Abort: assert abort in WAIT of phase 2 while req_wren[1]=1. Required: next cycle state_tap=0, mem_wren=0, busy=0; a start edge restarts with phase_start=0001.
- Async reset mid-run: assert reset between clock edges during DECRYPT. Required: all outputs go to 0 immediately, with no clock edge; after release, the sequencer idles until a start edge.
